// File: rtl/acl_frame_sequencer.sv
// Frame read controller for the ACL path: captures the Ethernet header from a FWFT FIFO,
// waits for a permit/deny verdict, then forwards the frame downstream or drains it.
module acl_frame_sequencer #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_WORDS = 379
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_fifo_data,
  input  logic              i_fifo_tlast,
  input  logic              i_fifo_invalid,
  output logic              o_rd_valid,
  output logic              o_hdr_valid,
  output logic [47:0]       o_dest_mac,
  output logic [47:0]       o_src_mac,
  output logic [15:0]       o_ether_type,
  input  logic              i_acl_done,
  input  logic              i_acl_permit,
  output logic [DATA_W-1:0] o_tx_data,
  output logic              o_tx_tvalid,
  output logic              o_tx_tlast,
  input  logic              i_tx_tready,
  output logic              o_frame_pass,
  output logic              o_frame_drop,
  output logic              o_err_runt,
  output logic              o_err_oversize
);

  localparam int unsigned      CNT_W    = $clog2(MAX_WORDS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_WORDS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_W3   = CNT_W'(3);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_LOOKUP, S_REPLAY, S_STREAM, S_DROP
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic [1:0]             rep_idx_q, rep_idx_d;
  logic                   hdr_last_q, hdr_last_d;
  logic [3:0][DATA_W-1:0] hdr_buf_q;
  logic                   hdr_wr;
  logic                   pass_d, drop_d, runt_d, oversize_d;

  // Frame word count saturates so an endless frame in DROP never wraps.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  assign o_dest_mac   = {hdr_buf_q[0], hdr_buf_q[1][31:16]};
  assign o_src_mac    = {hdr_buf_q[1][15:0], hdr_buf_q[2]};
  assign o_ether_type = hdr_buf_q[3][31:16];

  // Next-state, pop and egress decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rep_idx_d   = rep_idx_q;
    hdr_last_d  = hdr_last_q;
    hdr_wr      = 1'b0;
    pass_d      = 1'b0;
    drop_d      = 1'b0;
    runt_d      = 1'b0;
    oversize_d  = 1'b0;
    o_rd_valid  = 1'b0;
    o_tx_tvalid = 1'b0;
    o_tx_tlast  = 1'b0;
    o_tx_data   = '0;

    case (state_q)
      S_IDLE: begin
        cnt_d     = '0;
        rep_idx_d = '0;
        if (!i_fifo_invalid) state_d = S_HDR;
      end

      S_HDR: begin
        o_rd_valid = !i_fifo_invalid;
        if (!i_fifo_invalid) begin
          hdr_wr = 1'b1;
          cnt_d  = cnt_inc;
          if (cnt_q == CNT_W3) begin
            hdr_last_d = i_fifo_tlast;
            state_d    = S_LOOKUP;
          end else if (i_fifo_tlast) begin
            runt_d  = 1'b1;
            drop_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end

      S_LOOKUP: begin
        if (i_acl_done) begin
          if (i_acl_permit) begin
            state_d = S_REPLAY;
          end else begin
            drop_d  = 1'b1;
            state_d = hdr_last_q ? S_IDLE : S_DROP;
          end
        end
      end

      S_REPLAY: begin
        o_tx_tvalid = 1'b1;
        o_tx_data   = hdr_buf_q[rep_idx_q];
        o_tx_tlast  = (rep_idx_q == 2'd3) && hdr_last_q;
        if (i_tx_tready) begin
          rep_idx_d = rep_idx_q + 2'd1;
          if (rep_idx_q == 2'd3) begin
            if (hdr_last_q) begin
              pass_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              state_d = S_STREAM;
            end
          end
        end
      end

      // Pass-through straight from the FIFO head; the last allowed word is forced to tlast.
      S_STREAM: begin
        o_tx_tvalid = !i_fifo_invalid;
        o_tx_data   = i_fifo_data;
        o_tx_tlast  = i_fifo_tlast || (cnt_q == CNT_LAST);
        o_rd_valid  = !i_fifo_invalid && i_tx_tready;
        if (!i_fifo_invalid && i_tx_tready) begin
          cnt_d = cnt_inc;
          if (i_fifo_tlast) begin
            pass_d  = 1'b1;
            state_d = S_IDLE;
          end else if (cnt_q == CNT_LAST) begin
            pass_d     = 1'b1;
            oversize_d = 1'b1;
            state_d    = S_DROP;
          end
        end
      end

      S_DROP: begin
        o_rd_valid = !i_fifo_invalid;
        if (!i_fifo_invalid) begin
          cnt_d = cnt_inc;
          if (i_fifo_tlast) state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      rep_idx_q      <= '0;
      hdr_last_q     <= 1'b0;
      hdr_buf_q      <= '0;
      o_hdr_valid    <= 1'b0;
      o_frame_pass   <= 1'b0;
      o_frame_drop   <= 1'b0;
      o_err_runt     <= 1'b0;
      o_err_oversize <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rep_idx_q      <= rep_idx_d;
      hdr_last_q     <= hdr_last_d;
      if (hdr_wr) hdr_buf_q[cnt_q[1:0]] <= i_fifo_data;
      o_hdr_valid    <= (state_d == S_LOOKUP);
      o_frame_pass   <= pass_d;
      o_frame_drop   <= drop_d;
      o_err_runt     <= runt_d;
      o_err_oversize <= oversize_d;
    end
  end

endmodule
